// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserializes 10-bit command frames for the RAM and
// serializes the RAM's read data back on MISO. MOSI is sampled on clk while SS_n is low.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | slave not selected, counters cleared, MISO low
// CHK_CMD   | first frame bit sampled, selects the frame type
// WRITE     | receiving a write-address or write-data frame
// READ_ADD  | receiving a read-address frame
// READ_DATA | receiving a read-data frame, then returning one RAM byte
module spi_slave_if #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);

   localparam int FRAME_W  = DATA_W + 2;
   localparam int CNT_W    = $clog2(FRAME_W + 1);
   localparam int TX_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     bit_cnt;
   logic [FRAME_W-2:0]   rx_shift;
   logic                 rx_pend;
   logic                 addr_rcvd;
   logic [DATA_W-1:0]    tx_shift;
   logic [TX_CNT_W-1:0]  tx_cnt;
   logic                 tx_busy;
   logic                 tx_done;
   logic                 rx_shift_en;
   logic                 rx_last;
   logic                 rx_over;
   logic                 tx_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      rx_shift_en = 1'b0;
      rx_last     = 1'b0;
      rx_over     = 1'b0;
      tx_load     = 1'b0;
      case (state)
         IDLE: begin
            if (!SS_n) state_nxt = CHK_CMD;
         end
         CHK_CMD: begin
            if (SS_n) begin
               state_nxt = IDLE;
            end else begin
               rx_shift_en = 1'b1;
               if (!MOSI)          state_nxt = WRITE;
               else if (!addr_rcvd) state_nxt = READ_ADD;
               else                 state_nxt = READ_DATA;
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               state_nxt = IDLE;
            end else begin
               rx_shift_en = (bit_cnt < CNT_W'(FRAME_W));
               rx_last     = (bit_cnt == CNT_W'(FRAME_W - 1));
               rx_over     = (bit_cnt == CNT_W'(FRAME_W)) && !rx_pend;
               // one read byte per frame, only once the frame has been handed off
               tx_load     = (state == READ_DATA) && rx_over && !tx_busy && !tx_done && tx_valid;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_pend   <= 1'b0;
         addr_rcvd <= 1'b0;
         tx_shift  <= '0;
         tx_cnt    <= '0;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
         MISO      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state == IDLE || SS_n) begin
            bit_cnt <= '0;
            rx_pend <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            MISO    <= 1'b0;
         end else begin
            if (rx_shift_en) begin
               rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
               bit_cnt  <= bit_cnt + 1'b1;
            end
            if (rx_last) begin
               rx_data <= {rx_shift, MOSI};
               rx_pend <= 1'b1;
            end
            if (rx_pend) begin
               rx_valid <= 1'b1;
               rx_pend  <= 1'b0;
               if (state == READ_ADD && rx_data[FRAME_W-1 -: 2] == 2'b10) addr_rcvd <= 1'b1;
            end
            if (tx_load) begin
               tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
               tx_cnt   <= TX_CNT_W'(DATA_W - 1);
               tx_busy  <= 1'b1;
               MISO     <= tx_data[DATA_W-1];
            end else if (tx_busy) begin
               if (tx_cnt == '0) begin
                  tx_busy   <= 1'b0;
                  tx_done   <= 1'b1;
                  MISO      <= 1'b0;
                  addr_rcvd <= 1'b0;
               end else begin
                  tx_cnt   <= tx_cnt - 1'b1;
                  tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                  MISO     <= tx_shift[DATA_W-1];
               end
            end
         end
      end
   end

endmodule
